// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between the execute stage (id 0)
// and the branch/address unit (id 1). Optional grant counters: define ALU_ARB_PERF_EN.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [2:0]       i_req0_ctrl,
    input  logic [2:0]       i_req1_ctrl,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic [2:0]       o_alu_ctrl,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_zero,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_zero,
`ifdef ALU_ARB_PERF_EN
    output logic [15:0]      o_grant_cnt0,
    output logic [15:0]      o_grant_cnt1,
`endif
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last;
    logic [1:0] grant;
    logic       accept;

    // Grant is offered only in IDLE; on a tie the requester not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant = 2'b00;
        if (state == IDLE) begin
            case (i_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign o_req_ready = grant;
    assign accept      = |grant;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            o_alu_ctrl   <= 3'b000;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_zero   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_alu_ctrl <= grant[1] ? i_req1_ctrl : i_req0_ctrl;
                        o_alu_a    <= grant[1] ? i_req1_a    : i_req0_a;
                        o_alu_b    <= grant[1] ? i_req1_b    : i_req0_b;
                        o_rsp_id   <= grant[1];
                        last       <= grant[1];
                        o_busy     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_zero   <= i_alu_zero;
                    o_rsp_valid  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant[0] && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant[1] && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end

    assign o_grant_cnt0 = grant_cnt0;
    assign o_grant_cnt1 = grant_cnt1;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle datapath ALU between two requesters (req 0: execute stage, req 1: branch/address unit) by round-robin arbitration. It registers the granted operands and control code, drives the shared ALU for one cycle, and captures the result and zero flag into a response register. The response is returned on a shared response channel tagged with the requester id. The block sits between the control/decode logic and the ALU instance in the CPU top level.

## Interface
- WIDTH, 32, operand/result width in bits
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  2  per-requester request valid, bit i = requester i
- o_req_ready  out  2  per-requester accept; at most one bit high
- i_req0_ctrl, i_req1_ctrl  in  3  ALU control code (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL)
- i_req0_a, i_req0_b, i_req1_a, i_req1_b  in  WIDTH  operands
- o_alu_ctrl  out  3  to shared ALU control input
- o_alu_a, o_alu_b  out  WIDTH  to shared ALU operands
- i_alu_result  in  WIDTH  shared ALU result (combinational from o_alu_*)
- i_alu_zero  in  1  shared ALU zero flag
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accept
- o_rsp_id  out  1  requester id the response belongs to
- o_rsp_result  out  WIDTH  captured result
- o_rsp_zero  out  1  captured zero flag
- o_busy  out  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant chosen combinationally from i_req_valid and last-grant pointer `last`. One valid: grant it. Both valid: grant ~last. None: o_req_ready = 00.
- o_req_ready[g] high only in IDLE for the granted g. On i_req_valid[g] & o_req_ready[g]: latch ctrl/a/b of g, id = g, `last` = g, go to EXEC.
- EXEC: o_alu_ctrl/a/b driven from latched registers; capture i_alu_result, i_alu_zero into response registers; go to RESP.
- RESP: o_rsp_valid = 1; outputs stable until i_rsp_ready. On handshake go to IDLE.
- o_alu_* hold the last latched values outside EXEC (no toggling to save power); ALU output is ignored outside EXEC.
- Requesters hold valid and operands stable until accepted; a dropped valid before acceptance is legal and causes no grant.
- All 8 ctrl codes are passed through unmodified; no decoding.

## Timing
- Reset (async assert, sync-release assumed at top level): state IDLE, `last` = 1 (req 0 wins first tie), o_req_ready = 00, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_result = 0, o_rsp_zero = 0, o_alu_ctrl = 000, o_alu_a/b = 0, o_busy = 0.
- Accept at edge N; ALU driven in cycle N+1; o_rsp_valid high from cycle N+2.
- With i_rsp_ready held high: response handshake at edge N+2, next accept at edge N+3; throughput one op per 3 cycles.
- Backpressure: RESP held indefinitely; no new request accepted; o_req_ready = 00.
- Request arriving during EXEC/RESP waits; arbitration uses valids seen in IDLE only.
- Reset mid-operation (EXEC or RESP): in-flight op discarded, no response produced, all outputs to reset values immediately.

## Configuration
- ALU_ARB_PERF_EN defined: adds outputs o_grant_cnt0, o_grant_cnt1 (16 bits each), incremented on each accept of that requester, saturating at 16'hFFFF, reset to 0.
- Not defined: counters and ports absent; all other behaviour identical.

## Test plan
- Single req 0: ctrl 000, a=5, b=7 -> o_req_ready=01 same cycle, o_alu_ctrl=000 next cycle, o_rsp_valid with result 12, id 0, zero 0 two cycles after accept.
- Tie after reset: both valid, req0 SUB 9-9, req1 XOR 3^5 -> req 0 first (result 0, zero 1), then req 1 (result 6, id 1); both held valid continuously alternate 0,1,0,1.
- Backpressure: i_rsp_ready low 10 cycles in RESP -> o_rsp_* stable, o_req_ready=00, o_busy=1; release -> handshake, next accept one cycle later.
- Reset during EXEC: i_rst_n low mid-cycle -> o_rsp_valid never asserts, all outputs reset, next tie grants req 0.
- Back-to-back req 1 only with ready high, SLL 1<<4 then SRL 32>>2 -> results 16, 8, accepts exactly 3 cycles apart.
- ALU_ARB_PERF_EN: 3 grants req0, 2 req1 -> o_grant_cnt0=3, o_grant_cnt1=2; preset to 16'hFFFF via forcing, one more grant -> stays 16'hFFFF.
